// File: rtl/instr_loader_if.sv
// Bundles the program/consumer control, DDR burst-read and instruction-memory
// write signals of the instruction loader.
interface instr_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int DDR_AW = 32
);
  logic              start;
  logic [DDR_AW-1:0] prog_base;
  logic [15:0]       prog_len;
  logic              fetch_instruction_from_ddr;
  logic              i_mem_rd_enable;

  logic              ddr_rd_req;
  logic [DDR_AW-1:0] ddr_rd_addr;
  logic [7:0]        ddr_rd_len;
  logic              ddr_rd_ready;
  logic              ddr_rd_valid;
  logic [DATA_W-1:0] ddr_rd_data;

  logic              i_mem_wr_en;
  logic [ADDR_W-1:0] i_mem_wr_addr;
  logic [DATA_W-1:0] i_mem_wr_data;
  logic              i_mem_empty;
  logic              load_done;
  logic              busy;

  modport master (
    input  start, prog_base, prog_len, fetch_instruction_from_ddr, i_mem_rd_enable,
    input  ddr_rd_ready, ddr_rd_valid, ddr_rd_data,
    output ddr_rd_req, ddr_rd_addr, ddr_rd_len,
    output i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data, i_mem_empty, load_done, busy
  );

  modport slave (
    output start, prog_base, prog_len, fetch_instruction_from_ddr, i_mem_rd_enable,
    output ddr_rd_ready, ddr_rd_valid, ddr_rd_data,
    input  ddr_rd_req, ddr_rd_addr, ddr_rd_len,
    input  i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data, i_mem_empty, load_done, busy
  );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: pulls the program from DDR in bursts and fills the
// instruction memory as a circular buffer, tracking occupancy for the consumer.
//
// state | meaning
// IDLE  | waiting for start
// WAIT  | armed; waiting for fetch request and enough free space
// REQ   | burst request held on DDR until accepted
// DATA  | receiving burst beats, one i_mem write per beat
// DONE  | whole program written; start re-arms
module instr_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int DDR_AW    = 32,
  parameter int BURST_LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_loader_if.master bus
);

  localparam int                CW      = ADDR_W + 2;
  localparam logic [CW-1:0]     DEPTH_C = CW'(1) << ADDR_W;
  localparam logic [15:0]       BURST16 = 16'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DDR_AW-1:0]   r_base;
  logic [15:0]         r_remaining;
  logic [15:0]         r_fetched;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_count;
  logic [7:0]          r_beats_left;

  logic                r_rd_req;
  logic [DDR_AW-1:0]   r_rd_addr;
  logic [7:0]          r_rd_len;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  logic [7:0]          w_burst_len;
  logic [CW-1:0]       w_occ;
  logic                w_room;
  logic                w_arm;
  logic                w_fire;
  logic                w_accept;
  logic                w_beat;
  logic                w_rd_take;

  assign w_burst_len = (r_remaining < BURST16) ? r_remaining[7:0] : 8'(BURST_LEN);
  // A write still in flight already owns a slot, so count it as occupied.
  assign w_occ       = CW'(r_count) + CW'(r_wr_en);
  assign w_room      = (DEPTH_C - w_occ) >= CW'(w_burst_len);
  assign w_rd_take   = bus.i_mem_rd_enable && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_fire      = 1'b0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_arm       = 1'b1;
          w_state_nxt = (bus.prog_len == 16'd0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.fetch_instruction_from_ddr && (r_remaining != 16'd0) && w_room) begin
          w_fire      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.ddr_rd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.ddr_rd_valid) begin
          w_beat = 1'b1;
          if (r_beats_left == 8'd1) begin
            w_state_nxt = (r_remaining == 16'd1) ? S_DONE : S_WAIT;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_remaining  <= '0;
      r_fetched    <= '0;
      r_wr_ptr     <= '0;
      r_beats_left <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_len     <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= w_beat;
      if (w_arm) begin
        r_base      <= bus.prog_base;
        r_remaining <= bus.prog_len;
        r_fetched   <= '0;
        r_wr_ptr    <= '0;
      end
      if (w_fire) begin
        r_rd_req  <= 1'b1;
        r_rd_addr <= r_base + (DDR_AW'(r_fetched) << 3);
        r_rd_len  <= w_burst_len;
      end
      if (w_accept) begin
        r_rd_req     <= 1'b0;
        r_beats_left <= r_rd_len;
      end
      if (w_beat) begin
        r_wr_addr    <= r_wr_ptr;
        r_wr_data    <= bus.ddr_rd_data;
        r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
        r_fetched    <= r_fetched + 16'd1;
        r_remaining  <= r_remaining - 16'd1;
        r_beats_left <= r_beats_left - 8'd1;
      end
    end
  end

  // Occupancy: a write and a read in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_arm) begin
      r_count <= '0;
    end else if (r_wr_en && !w_rd_take) begin
      r_count <= r_count + (ADDR_W+1)'(1);
    end else if (!r_wr_en && w_rd_take) begin
      r_count <= r_count - (ADDR_W+1)'(1);
    end
  end

  assign bus.ddr_rd_req    = r_rd_req;
  assign bus.ddr_rd_addr   = r_rd_addr;
  assign bus.ddr_rd_len    = r_rd_len;
  assign bus.i_mem_wr_en   = r_wr_en;
  assign bus.i_mem_wr_addr = r_wr_addr;
  assign bus.i_mem_wr_data = r_wr_data;
  assign bus.i_mem_empty   = (r_count == '0);
  assign bus.load_done     = (r_state == S_DONE);
  assign bus.busy          = (r_state == S_WAIT) || (r_state == S_REQ) || (r_state == S_DATA);

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Producer side of the instruction-memory interface. The top-level FSM consumes instructions and raises a fetch request when the memory runs empty; this block services that request.
- On each fetch request it reads bursts of 64-bit instructions from DDR through a simple request/beat handshake. It writes them into the instruction memory as a circular buffer.
- It owns the occupancy count and drives i_mem_empty back to the consumer.

Parameters:
ADDR_W, 10, instruction memory address width (depth = 2^ADDR_W)
DATA_W, 64, instruction width in bits
DDR_AW, 32, DDR byte-address width
BURST_LEN, 16, maximum instructions per DDR burst (must be ≤ 2^ADDR_W)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  one-cycle pulse; latches program base address and length, then arms the loader
prog_base  in  DDR_AW  DDR byte address of the first instruction (8-byte aligned)
prog_len  in  16  number of instructions in the program
fetch_instruction_from_ddr  in  1  level request from the consumer FSM
i_mem_rd_enable  in  1  consumer read strobe; one pulse per instruction consumed
ddr_rd_req  out  1  burst read request, held until accepted
ddr_rd_addr  out  DDR_AW  burst start byte address
ddr_rd_len  out  8  beats in burst (1..BURST_LEN)
ddr_rd_ready  in  1  request accepted in a cycle where ddr_rd_req=1
ddr_rd_valid  in  1  data beat valid
ddr_rd_data  in  DATA_W  data beat
i_mem_wr_en  out  1  instruction memory write strobe
i_mem_wr_addr  out  ADDR_W  write address
i_mem_wr_data  out  DATA_W  write data
i_mem_empty  out  1  occupancy == 0
load_done  out  1  whole program written to i_mem
busy  out  1  state not IDLE/DONE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all pointers and counters = 0.
  - ddr_rd_req=0, ddr_rd_addr=0, ddr_rd_len=0.
  - i_mem_wr_en=0, i_mem_wr_addr=0, i_mem_wr_data=0.
  - load_done=0, busy=0.
  - i_mem_empty=1.
  - Reset mid-burst discards the burst; any later ddr_rd_valid beats are ignored.
- Registers:
  - base, remaining (16b), fetched (16b), wr_ptr (ADDR_W, wraps modulo 2^ADDR_W), count (ADDR_W+1b), beats_left (8b).
- States:
  - IDLE: start=1 → base=prog_base, remaining=prog_len, fetched=0, wr_ptr=0, count=0, load_done=0. Next state is WAIT, or DONE if prog_len=0.
  - WAIT: go to REQ when fetch_instruction_from_ddr=1 and remaining>0 and (2^ADDR_W − count) ≥ min(BURST_LEN, remaining). Otherwise stay.
  - REQ: ddr_rd_req=1, ddr_rd_addr=base+fetched*8, ddr_rd_len=min(BURST_LEN, remaining). Address and length are registered on entry and stable while req=1. On ddr_rd_ready: ddr_rd_req=0 next cycle, beats_left=len, → DATA.
  - DATA: each cycle with ddr_rd_valid=1 gives a registered write one cycle later:
    - i_mem_wr_en=1, i_mem_wr_addr=wr_ptr, i_mem_wr_data=ddr_rd_data.
    - wr_ptr+1, fetched+1, remaining−1, beats_left−1.
    - When the last beat is taken: → DONE if remaining becomes 0, else → WAIT.
  - DONE: load_done=1. start=1 re-arms exactly as in IDLE and clears load_done.
- Request handling:
  - A burst, once requested, always completes, even if fetch_instruction_from_ddr drops mid-burst.
  - fetch_instruction_from_ddr is sampled only in WAIT.
- Occupancy (count):
  - +1 on each i_mem_wr_en cycle; −1 on i_mem_rd_enable when count>0.
  - Simultaneous write and read → unchanged.
  - i_mem_rd_enable with count=0 is ignored; no underflow.
  - i_mem_empty = (count==0), driven from the register.
  - The free-space check in WAIT guarantees count never exceeds 2^ADDR_W.
- Inputs ignored by state:
  - start is ignored in WAIT, REQ and DATA.
  - ddr_rd_valid is ignored outside DATA.
  - i_mem_wr_en is never asserted outside DATA+1.
- Latencies:
  - fetch request in WAIT → ddr_rd_req high: 1 cycle.
  - Beat in → i_mem_wr_en: 1 cycle.
  - Write → i_mem_empty deasserts: 1 cycle.

Test Plan:
- Basic load: prog_base=0x1000, prog_len=5, fetch held high, ready immediate, 5 consecutive valid beats D0..D4 → one request (addr 0x1000, len 5), i_mem writes at addr 0..4 with D0..D4, i_mem_empty falls 2 cycles after first beat, load_done=1 after the last write.
- Multi-burst: prog_len=40, BURST_LEN=16 → three requests with (addr,len) = (base,16), (base+128,16), (base+256,8); gaps between beats tolerated; 40 writes total.
- Backpressure/full: ADDR_W=4, prog_len=32, no reads → after 16 writes count=16 and the loader stays in WAIT. Then 16 i_mem_rd_enable pulses → next burst issued; wr_ptr wraps, the 17th write goes to addr 0.
- Simultaneous events: a write beat and i_mem_rd_enable in the same cycle with count=3 → count stays 3. i_mem_rd_enable with count=0 → count stays 0 and i_mem_empty stays 1.
- Reset mid-burst: rst_n low during DATA after 3 of 16 beats → all outputs at reset values immediately. Trailing valid beats cause no writes; state stays IDLE until start.
- Edge cases: prog_len=0 with start → DONE in 1 cycle with no ddr_rd_req. start pulsed during DATA → ignored; the burst completes normally.
